dmem_initiator: RTL and testbench

DMEM_INITIATOR -- requirements
Module: dmem_initiator

---
 rtl/dmem_initiator.sv | 186 ++++++++++++++++++
 tb/tb_dmem_initiator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_initiator.sv
// dmem_initiator: burst initiator toward a simple data-memory/IO bus.
//
// Accepts one command at a time (write or read burst of cmd_len words) and
// converts it into single-word bus accesses on addr/datain/we. Read data
// returns on dataout RD_LATENCY cycles after the address and is forwarded
// to rd_valid/rd_data in issue order.
//
// Parameters:
//   RD_LATENCY  memory read latency in cycles (1 or 2)
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; ready only when idle
//   cmd_write, cmd_addr, cmd_len  burst direction, start byte address, words
//   wr_valid/wr_ready/wr_data     write-data stream
//   rd_valid/rd_data              read-data stream (no backpressure)
//   addr, datain, we, dataout     memory bus
//   busy, done, err               status; done/err pulse in the final cycle
// Build option:
//   DMEM_INITIATOR_IO_GUARD_EN    reject bursts whose first and last word
//                                 addresses differ in bit 7 (RAM/IO mix)
module dmem_initiator #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [4:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        we,
  input  logic [31:0] dataout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StDrain, StFin} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             cur_addr_q, cur_addr_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [31:0]             last_addr_q, last_addr_d;
  logic [31:0]             last_data_q, last_data_d;
  logic [RD_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;
`ifdef DMEM_INITIATOR_IO_GUARD_EN
  logic                    err_q, err_d;
  logic [31:0]             last_word;
`endif

  logic [31:0]             first_word;
  logic                    reject;
  logic                    wr_beat;
  logic                    rd_issue;
  logic [RD_LATENCY-1:0]   pipe_rest;
  logic                    rd_final;

  assign first_word = cmd_addr & 32'hFFFF_FFFC;
  assign wr_beat    = (state_q == StWr) && wr_valid;
  assign rd_issue   = (state_q == StRd);

`ifdef DMEM_INITIATOR_IO_GUARD_EN
  assign last_word = first_word + {25'd0, cmd_len - 5'd1, 2'b00};
  assign reject    = (cmd_len != 5'd0) && (first_word[7] != last_word[7]);
`else
  assign reject    = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      rd_pipe_q   <= '0;
`ifdef DMEM_INITIATOR_IO_GUARD_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      rd_pipe_q   <= rd_pipe_d;
`ifdef DMEM_INITIATOR_IO_GUARD_EN
      err_q       <= err_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
`ifdef DMEM_INITIATOR_IO_GUARD_EN
    err_d       = err_q;
`endif

    // Read-return tracker: bit i set means a read issued i+1 cycles ago
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    pipe_rest                 = rd_pipe_q;
    pipe_rest[RD_LATENCY-1]   = 1'b0;
    rd_final = rd_pipe_q[RD_LATENCY-1] && (pipe_rest == '0);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cur_addr_d = first_word;
          cnt_d      = cmd_len;
          if (cmd_len == 5'd0) begin
            state_d = StFin;
          end else if (reject) begin
            state_d = StFin;
`ifdef DMEM_INITIATOR_IO_GUARD_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d = cmd_write ? StWr : StRd;
          end
        end
      end
      StWr: begin
        if (wr_valid) begin
          cur_addr_d  = cur_addr_q + 32'd4;
          cnt_d       = cnt_q - 5'd1;
          last_addr_d = cur_addr_q;
          last_data_d = wr_data;
          if (cnt_q == 5'd1) state_d = StFin;
        end
      end
      StRd: begin
        cur_addr_d  = cur_addr_q + 32'd4;
        cnt_d       = cnt_q - 5'd1;
        last_addr_d = cur_addr_q;
        if (cnt_q == 5'd1) state_d = StDrain;
      end
      StDrain: begin
        if (rd_final) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
`ifdef DMEM_INITIATOR_IO_GUARD_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; reset forces every output to its idle value immediately
  always_comb begin
    cmd_ready = !reset && (state_q == StIdle);
    busy      = !reset && (state_q != StIdle);
    done      = !reset && (state_q == StFin);
    wr_ready  = !reset && (state_q == StWr);
    we        = !reset && wr_beat;
    rd_valid  = !reset && rd_pipe_q[RD_LATENCY-1];
    rd_data   = reset ? 32'd0 : dataout;
    // Bus holds the last presented address/data while no access is made
    addr      = reset ? 32'd0 : ((wr_beat || rd_issue) ? cur_addr_q : last_addr_q);
    datain    = reset ? 32'd0 : (wr_beat ? wr_data : last_data_q);
`ifdef DMEM_INITIATOR_IO_GUARD_EN
    err       = !reset && (state_q == StFin) && err_q;
`else
    err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator. Two instances share all inputs: dut1
// uses RD_LATENCY=1, dut2 uses RD_LATENCY=2, each with its own memory model.
module tb_dmem_initiator;

  logic        clock = 1'b0;
  logic        reset, cmd_valid, cmd_write, wr_valid;
  logic [31:0] cmd_addr, wr_data;
  logic [4:0]  cmd_len;

  logic        cmd_ready1, wr_ready1, rd_valid1, we1, busy1, done1, err1;
  logic [31:0] rd_data1, addr1, datain1, dataout1;
  logic        cmd_ready2, wr_ready2, rd_valid2, we2, busy2, done2, err2;
  logic [31:0] rd_data2, addr2, datain2, dataout2, d2a;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];

  int checks = 0;
  int errors = 0;

  // Status vector: {cmd_ready, wr_ready, we, rd_valid, busy, done}
  wire [5:0] st1 = {cmd_ready1, wr_ready1, we1, rd_valid1, busy1, done1};
  wire [5:0] st2 = {cmd_ready2, wr_ready2, we2, rd_valid2, busy2, done2};

  always #5 clock = ~clock;

  dmem_initiator #(.RD_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .addr(addr1), .datain(datain1),
    .we(we1), .dataout(dataout1), .busy(busy1), .done(done1), .err(err1)
  );

  dmem_initiator #(.RD_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_data(wr_data),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .addr(addr2), .datain(datain2),
    .we(we2), .dataout(dataout2), .busy(busy2), .done(done2), .err(err2)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'd0;
      mem2[i] = 32'd0;
    end
  end

  always @(posedge clock) begin
    if (we1) mem1[addr1[9:2]] <= datain1;
    if (we2) mem2[addr2[9:2]] <= datain2;
    dataout1 <= mem1[addr1[9:2]];
    d2a      <= mem2[addr2[9:2]];
    dataout2 <= d2a;
  end

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [4:0] len);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    #1;
    checks++;
    if ({cmd_ready1, cmd_ready2} !== 2'b11) begin
      errors++;
      $display("FAIL cmd_accept: got ready=%b required 11", {cmd_ready1, cmd_ready2});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    checks++;
    if ({st1, st2} !== 12'b0) begin
      errors++; $display("FAIL reset_status: got %b required 0", {st1, st2});
    end
    checks++;
    if ({addr1, datain1, rd_data1, err1} !== 97'd0) begin
      errors++; $display("FAIL reset_bus: got %h %h %h %b required zeros",
                         addr1, datain1, rd_data1, err1);
    end
    @(negedge clock); reset = 1'b0; #1;
    checks++;
    if (st1 !== 6'b100000) begin
      errors++; $display("FAIL reset_release: got %b required 100000", st1);
    end
  endtask

  task automatic test_write();
    logic        v  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d  [4] = '{32'hA, 32'h0, 32'hB, 32'hC};
    logic [31:0] ea [4] = '{32'h10, 32'h10, 32'h14, 32'h18};
    logic [31:0] ed [4] = '{32'hA, 32'hA, 32'hB, 32'hC};
    send_cmd(1'b1, 32'h10, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      cmd_valid = 1'b0; wr_valid = v[i]; wr_data = d[i];
      #1;
      checks++;
      if (st1 !== {2'b01, v[i], 3'b010}) begin
        errors++; $display("FAIL write_beat%0d_status: got %b required %b",
                           i, st1, {2'b01, v[i], 3'b010});
      end
      checks++;
      if ({addr1, datain1} !== {ea[i], ed[i]}) begin
        errors++; $display("FAIL write_beat%0d_bus: got %h/%h required %h/%h",
                           i, addr1, datain1, ea[i], ed[i]);
      end
    end
    @(negedge clock); wr_valid = 1'b0; #1;
    checks++;
    if ({st1, err1, addr1, datain1} !== {6'b000011, 1'b0, 32'h18, 32'hC}) begin
      errors++; $display("FAIL write_done: got %b %b %h %h required 000011 0 18 c",
                         st1, err1, addr1, datain1);
    end
    @(negedge clock); #1;
    checks++;
    if (st1 !== 6'b100000) begin
      errors++; $display("FAIL write_idle: got %b required 100000", st1);
    end
  endtask

  task automatic test_read();
    logic [31:0] ea;
    send_cmd(1'b0, 32'h10, 5'd3);
    for (int c = 1; c <= 6; c++) begin
      logic rv1, rv2;
      @(negedge clock); cmd_valid = 1'b0; #1;
      ea  = (c <= 3) ? 32'h10 + 32'(4 * (c - 1)) : 32'h18;
      rv1 = (c >= 2) && (c <= 4);
      rv2 = (c >= 3) && (c <= 5);
      if (c <= 4) begin
        checks++;
        if ({addr1, addr2} !== {ea, ea}) begin
          errors++; $display("FAIL read_c%0d_addr: got %h/%h required %h", c, addr1, addr2, ea);
        end
      end
      checks++;
      if ({we1, rv1 ? 1'b0 : rd_valid1, done1, we2, rv2 ? 1'b0 : rd_valid2, done2}
          !== {1'b0, 1'b0, c == 5, 1'b0, 1'b0, c == 6} || rd_valid1 !== rv1
          || rd_valid2 !== rv2) begin
        errors++; $display("FAIL read_c%0d_status: got %b/%b required rv=%b/%b done@5/6",
                           c, st1, st2, rv1, rv2);
      end
      if (rv1) begin
        checks++;
        if (rd_data1 !== 32'hA + 32'(c - 2)) begin
          errors++; $display("FAIL read1_c%0d_data: got %h required %h",
                             c, rd_data1, 32'hA + 32'(c - 2));
        end
      end
      if (rv2) begin
        checks++;
        if (rd_data2 !== 32'hA + 32'(c - 3)) begin
          errors++; $display("FAIL read2_c%0d_data: got %h required %h",
                             c, rd_data2, 32'hA + 32'(c - 3));
        end
      end
    end
    @(negedge clock); #1;
    checks++;
    if ({st1, st2} !== {6'b100000, 6'b100000}) begin
      errors++; $display("FAIL read_idle: got %b/%b required 100000", st1, st2);
    end
  endtask

  task automatic test_len0();
    send_cmd(1'b0, 32'h200, 5'd0);
    @(negedge clock); cmd_valid = 1'b0; #1;
    checks++;
    if ({st1, st2, addr1} !== {6'b000011, 6'b000011, 32'h18}) begin
      errors++; $display("FAIL len0_done: got %b/%b addr %h required 000011 addr 18",
                         st1, st2, addr1);
    end
    @(negedge clock); #1;
    checks++;
    if (st1 !== 6'b100000) begin
      errors++; $display("FAIL len0_idle: got %b required 100000", st1);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [2] = '{32'hFFFF_FFFC, 32'h0000_0000};
    send_cmd(1'b1, 32'hFFFF_FFFE, 5'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'h11 * (i + 1); #1;
      checks++;
      if ({we1, addr1} !== {1'b1, ea[i]}) begin
        errors++; $display("FAIL wrap_beat%0d: got we=%b addr=%h required 1 %h",
                           i, we1, addr1, ea[i]);
      end
    end
    @(negedge clock); wr_valid = 1'b0; #1;
    checks++;
    if (st1 !== 6'b000011) begin
      errors++; $display("FAIL wrap_done: got %b required 000011", st1);
    end
    @(negedge clock); #1;
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b1, 32'h40, 5'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'(i + 1); #1;
    end
    @(negedge clock); reset = 1'b1; wr_data = 32'd3; #1;
    @(negedge clock); #1;
    checks++;
    if ({st1, addr1, datain1} !== {6'b0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL midreset_outputs: got %b %h %h required 0 0 0",
                         st1, addr1, datain1);
    end
    @(negedge clock); reset = 1'b0; #1;
    checks++;
    if (st1 !== 6'b100000) begin
      errors++; $display("FAIL midreset_release: got %b required 100000", st1);
    end
    @(negedge clock); wr_valid = 1'b0; #1;
    checks++;
    if ({st1, mem1[17], mem1[18]} !== {6'b100000, 32'd2, 32'd0}) begin
      errors++; $display("FAIL midreset_abort: got %b mem %h %h required 100000 2 0",
                         st1, mem1[17], mem1[18]);
    end
  endtask

  task automatic test_io_guard();
    send_cmd(1'b0, 32'h78, 5'd4);
`ifdef DMEM_INITIATOR_IO_GUARD_EN
    @(negedge clock); cmd_valid = 1'b0; #1;
    checks++;
    if ({st1, err1, addr1} !== {6'b000011, 1'b1, 32'd0}) begin
      errors++; $display("FAIL guard_reject: got %b err=%b addr=%h required 000011 1 0",
                         st1, err1, addr1);
    end
    @(negedge clock); #1;
    checks++;
    if ({st1, err1} !== {6'b100000, 1'b0}) begin
      errors++; $display("FAIL guard_idle: got %b err=%b required 100000 0", st1, err1);
    end
`else
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock); cmd_valid = 1'b0; #1;
      if (c <= 4) begin
        checks++;
        if ({we1, addr1} !== {1'b0, 32'h78 + 32'(4 * (c - 1))}) begin
          errors++; $display("FAIL guard_c%0d_addr: got we=%b %h required 0 %h",
                             c, we1, addr1, 32'h78 + 32'(4 * (c - 1)));
        end
      end
      checks++;
      if ({done1, err1, err2} !== {c == 6, 2'b00}) begin
        errors++; $display("FAIL guard_c%0d_status: got done=%b err=%b/%b required %b 0",
                           c, done1, err1, err2, c == 6);
      end
    end
    @(negedge clock); #1;
    checks++;
    if ({cmd_ready1, cmd_ready2} !== 2'b11) begin
      errors++; $display("FAIL guard_idle: got %b required 11", {cmd_ready1, cmd_ready2});
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_len0();
    test_wrap();
    test_reset_mid();
    test_io_guard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
